// File: rtl/dmem_pkg.sv
// Shared encodings and lane/extension helpers for the data-memory controller.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Byte-lane enables for a store; reserved size behaves as a word.
    function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] en;
        case (sz)
            SZ_B:    en = 4'b0001 << a;
            SZ_H:    en = a[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    function automatic logic [31:0] store_align(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{wd[7:0]}};
            SZ_H:    r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] a, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {a, 3'b000};
        case (sz)
            SZ_B:    r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    r = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        logic m;
        case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Four-lane byte-writable RAM: clocked write per lane, combinational read.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Per-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (we[lane]) begin
                mem_q[widx][lane*8 +: 8] <= wdata[lane*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller with wait states, pipeline stall and misalignment flag.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          store_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, mis_q;

    logic          req_s, commit_s, mis_s;
    logic [AW+1:0] eff_addr_s;
    logic [31:0]   eff_wdata_s;
    logic [1:0]    eff_size_s;
    logic          eff_uns_s, eff_store_s;
    logic [3:0]    we_s;
    logic [31:0]   ram_rdata_s;
    logic          unused_addr_s;

    assign req_s         = mem_read | mem_write;
    assign unused_addr_s = ^addr[31:AW+2];

    // With no wait states the commit happens in IDLE, straight from the live inputs.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eff_addr_s  = addr[AW+1:0];
            eff_wdata_s = wdata;
            eff_size_s  = size;
            eff_uns_s   = unsigned_ld;
            eff_store_s = mem_write;
        end else begin
            eff_addr_s  = addr_q;
            eff_wdata_s = wdata_q;
            eff_size_s  = size_q;
            eff_uns_s   = uns_q;
            eff_store_s = store_q;
        end
    end

    always_comb begin
        commit_s = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    if (NO_WAIT) begin
                        commit_s = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit_s = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall = ((state_q == ST_IDLE) && req_s) || (state_q == ST_WAIT);
    assign mis_s = is_misaligned(eff_size_s, eff_addr_s[1:0]);

    // Reset on the commit edge suppresses the write.
    always_comb begin
        if (commit_s && eff_store_s && !mis_s && !rst) begin
            we_s = lane_en(eff_size_s, eff_addr_s[1:0]);
        end else begin
            we_s = 4'b0000;
        end
    end

    always_comb begin
        if (commit_s && mis_s) begin
            rdata_d = 32'h0000_0000;
        end else if (commit_s && !eff_store_s) begin
            rdata_d = load_ext(ram_rdata_s, eff_size_s, eff_addr_s[1:0], eff_uns_s);
        end else begin
            rdata_d = rdata_q;
        end
    end

    // FSM, counter, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == ST_IDLE) && req_s) begin
                addr_q  <= addr[AW+1:0];
                wdata_q <= wdata;
                size_q  <= size;
                uns_q   <= unsigned_ld;
                store_q <= mem_write;
            end
            rdata_q <= rdata_d;
            done_q  <= commit_s;
            mis_q   <= commit_s & mis_s;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .widx  (eff_addr_s[AW+1:2]),
        .wdata (store_align(eff_size_s, eff_wdata_s)),
        .ridx  (eff_addr_s[AW+1:2]),
        .rdata (ram_rdata_s)
    );

    assign rdata        = rdata_q;
    assign done         = done_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: a 2-wait-state controller and a zero-wait-state controller.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        stall, done, misalign_err;

    logic        mem_read0, mem_write0, unsigned_ld0;
    logic [1:0]  size0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        stall0, done0, misalign_err0;

    int          n_assert = 0;
    int          n_fail   = 0;

    int          t_stalls, t_cycles;
    logic        t_seen, t_mis, t_done_after;
    logic [31:0] t_rdata;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .done(done), .misalign_err(misalign_err)
    );

    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(mem_read0), .mem_write(mem_write0), .size(size0),
        .unsigned_ld(unsigned_ld0), .addr(addr0), .wdata(wdata0), .rdata(rdata0),
        .stall(stall0), .done(done0), .misalign_err(misalign_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the 2-wait-state controller; results land in t_* variables.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
        #1;
        t_stalls = stall ? 1 : 0;
        t_cycles = 0;
        t_seen   = 1'b0;
        t_mis    = 1'b0;
        t_rdata  = 32'hxxxx_xxxx;
        for (int i = 0; i < 20 && !t_seen; i++) begin
            @(posedge clk); #1;
            t_cycles++;
            if (done) begin
                t_seen  = 1'b1;
                t_mis   = misalign_err;
                t_rdata = rdata;
            end else if (stall) begin
                t_stalls++;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        t_done_after = done;
        if (!t_seen) check("access_timeout", 32'(t_seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        mem_read0 = 1'b0; mem_write0 = 1'b0; size0 = 2'b10; unsigned_ld0 = 1'b0;
        addr0 = 32'h0; wdata0 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mis", 32'(misalign_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // Aligned word store and its latency
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("st_stalls", 32'(t_stalls), 32'd3);
        check("st_latency", 32'(t_cycles), 32'd3);
        check("st_mis", 32'(t_mis), 32'd0);
        check("st_done_pulse", 32'(t_done_after), 32'd0);
        check("st_rdata_hold", t_rdata, 32'h0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("ld_word", t_rdata, 32'hDEADBEEF);
        check("ld_latency", 32'(t_cycles), 32'd3);

        // Extension
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
        check("st_keeps_rdata", t_rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
        check("lb_s_23", t_rdata, 32'hFFFFFF80);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        check("lb_u_23", t_rdata, 32'h00000080);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("lh_s_22", t_rdata, 32'hFFFF80FF);
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        check("lh_u_20", t_rdata, 32'h00007F01);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        check("lb_s_21", t_rdata, 32'h0000007F);
        access(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        check("ld_rsvd_size", t_rdata, 32'h80FF7F01);

        // Partial store
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("sb_merge", t_rdata, 32'h1122AA44);

        // Misaligned
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h55555555);
        check("mis_st_flag", 32'(t_mis), 32'd1);
        check("mis_st_rdata", t_rdata, 32'h0);
        check("mis_st_latency", 32'(t_cycles), 32'd3);
        check("mis_pulse", 32'(misalign_err), 32'd0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("mis_st_nowrite", t_rdata, 32'h1122AA44);
        check("aligned_no_mis", 32'(t_mis), 32'd0);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        check("mis_lh_flag", 32'(t_mis), 32'd1);
        check("mis_lh_rdata", t_rdata, 32'h0);

        // Wrap and read+write overlap
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
        check("wrap", t_rdata, 32'hCAFEF00D);
        access(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
        check("rw_mis", 32'(t_mis), 32'd0);
        check("rw_rdata_hold", t_rdata, 32'hCAFEF00D);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        check("rw_stored", t_rdata, 32'h12345678);

        // Reset in the last wait cycle of a store
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304);
        @(negedge clk);
        mem_write = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_stall", 32'(stall), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_write = 1'b0;
        #1;
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_idle", 32'(stall), 32'd0);
        check("rst_mid_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        check("rst_mid_done2", 32'(done), 32'd0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        check("rst_mid_nowrite", t_rdata, 32'h01020304);

        // Zero wait states, back-to-back
        @(negedge clk);
        mem_write0 = 1'b1; size0 = 2'b10; addr0 = 32'h8; wdata0 = 32'hA5A55A5A;
        #1;
        check("z_st_stall", 32'(stall0), 32'd1);
        @(posedge clk); #1;
        check("z_st_done", 32'(done0), 32'd1);
        check("z_st_stall_done", 32'(stall0), 32'd0);
        mem_write0 = 1'b0; mem_read0 = 1'b1;
        #1;
        check("z_done_ignores", 32'(stall0), 32'd0);
        @(posedge clk); #1;
        check("z_ld1_stall", 32'(stall0), 32'd1);
        check("z_ld1_nodone", 32'(done0), 32'd0);
        @(posedge clk); #1;
        check("z_ld1_done", 32'(done0), 32'd1);
        check("z_ld1_rdata", rdata0, 32'hA5A55A5A);
        check("z_ld1_stall0", 32'(stall0), 32'd0);
        @(posedge clk); #1;
        check("z_ld2_stall", 32'(stall0), 32'd1);
        check("z_ld2_nodone", 32'(done0), 32'd0);
        size0 = 2'b01; unsigned_ld0 = 1'b1; addr0 = 32'hA;
        @(posedge clk); #1;
        check("z_ld2_done", 32'(done0), 32'd1);
        check("z_ld2_rdata", rdata0, 32'h0000A5A5);
        mem_read0 = 1'b0;
        @(posedge clk); #1;
        check("z_idle_done", 32'(done0), 32'd0);
        check("z_idle_stall", 32'(stall0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller that answers the load/store requests raised by the instruction decoder's MemRead/MemWrite control lines. It owns a byte-lane data RAM and models a slow memory with a configurable wait-state count. While an access is in flight it stalls the core. It returns sign- or zero-extended load data and flags misaligned accesses.

## Interface
Parameters:
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two.
- WAIT_CYCLES, 2: wait states inserted before each access commits; 0..15.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- mem_read  in  1  load request, driven by the decoder's MemRead.
- mem_write  in  1  store request, driven by the decoder's MemWrite.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend.
- addr  in  32  byte address from the ALU result.
- wdata  in  32  store data, right-aligned in bits [N-1:0].
- rdata  out  32  extended load data; registered.
- stall  out  1  1 = hold the pipeline; the core keeps all inputs stable.
- done  out  1  one-cycle pulse when the access completes.
- misalign_err  out  1  one-cycle pulse with done when the access was misaligned.

## Operation
- States are IDLE, WAIT and DONE.
- IDLE:
  - A request (mem_read or mem_write) is latched: addr, wdata, size, unsigned_ld and the op.
  - WAIT_CYCLES>0 goes to WAIT with the counter set to WAIT_CYCLES-1.
  - WAIT_CYCLES=0 commits and goes to DONE directly.
- WAIT:
  - The counter decrements every cycle.
  - At counter==0 the access commits and the FSM goes to DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
  - Requests are ignored in DONE; the core advances on this cycle.
- Commit for a store:
  - Only the selected byte lanes are written.
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
- Commit for a load:
  - The selected lanes are shifted to bit 0 and extended per unsigned_ld.
  - The result is registered into rdata.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - The RAM is not written.
  - rdata is set to 0.
  - misalign_err pulses with done.
  - The wait states still elapse.
- Both mem_read and mem_write high: treated as a store, with no error.
- Address decode: word index = addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size.
- rdata holds its last value until the next load commits or a misaligned access occurs. Stores leave rdata unchanged.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - rdata=0, done=0, misalign_err=0.
  - stall=0 when no request is present.
  - RAM contents are not reset.
- stall is combinational:
  - 1 in IDLE while a request is present.
  - 1 throughout WAIT.
  - 0 in DONE.
- Latency: a request first seen in IDLE at cycle T gives stall=1 for cycles T..T+WAIT_CYCLES and done=1 at T+WAIT_CYCLES+1.
- rdata is valid in the done cycle.
- Back-to-back accesses: a new request can be accepted in IDLE on the cycle after DONE.
- Reset mid-operation:
  - rst has priority on every edge.
  - A commit scheduled on the same edge as rst is suppressed: no RAM write and rdata is cleared.
- The RAM write and the rdata load happen on the same edge; a load never sees a write from the same access.

## Structure
- Package dmem_pkg holds:
  - State encoding: IDLE, WAIT, DONE.
  - Size codes: SZ_B, SZ_H, SZ_W.
  - A function for lane-enable generation.
  - A function for load extraction and extension.
- Sub-module dmem_array: a 4-lane byte-writable synchronous RAM.
  - Ports: clk, we[3:0], widx, wdata, ridx, rdata.
  - No reset.
- dmem_ctrl contains the FSM, the wait counter, the request latch and the alignment logic.

## Test plan
- Aligned word, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x10.
  - Expect stall high for 3 cycles and done in cycle 4.
  - A later word load from 0x10 returns rdata=0xDEADBEEF.
- Byte and half extension, RAM word at 0x20 = 0x80FF7F01:
  - Signed byte load at 0x23 returns 0xFFFFFF80.
  - Unsigned byte load at 0x23 returns 0x00000080.
  - Signed half load at 0x22 returns 0xFFFF80FF.
- Partial store:
  - Byte store of 0xAA to 0x21 over 0x11223344.
  - A word load then returns 0x1122AA44.
- Misaligned accesses:
  - Word store to 0x22 → misalign_err pulses with done and the RAM is unchanged.
  - Half load at 0x21 → rdata=0.
- Wrap and overlap, DEPTH_WORDS=256:
  - Store to 0x400 then load from 0x000 returns the same data.
  - A request with both mem_read and mem_write high performs a store.
- Reset and back-to-back:
  - Assert rst in the last WAIT cycle of a store → no write; the FSM is in IDLE with done=0.
  - WAIT_CYCLES=0 with consecutive loads → stall is 1 for one cycle per load, and done alternates.
